oven_ctrl: RTL and testbench

//  Sequencing controller for the countdown timer (MM:SS, four BCD digits).

---
 rtl/oven_pkg.sv | 20 ++
 rtl/oven_ctrl_if.sv | 30 +++
 rtl/oven_ctrl_rise_det.sv | 21 ++
 rtl/oven_ctrl.sv | 159 +++++++++++++++
 tb/tb_oven_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oven_pkg.sv
// oven_pkg: state encoding, digit width and a BCD helper shared by the oven
// sequencing controller, its bus interface and its testbench.
package oven_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_COOKING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Keypad codes 10-15 are not digits and must never reach the timer.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
    return digit <= DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/oven_ctrl_if.sv
// oven_ctrl_if: keypad/button/door inputs and timer/magnetron outputs of the
// oven controller. The controller takes the slave side; the oven top level
// (or a testbench) takes the master side.
interface oven_ctrl_if;
  import oven_pkg::*;

  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               start_btn;
  logic               stop_btn;
  logic               door_closed;
  logic               timer_zero;
  logic [DIGIT_W-1:0] timer_data;
  logic               timer_loadn;
  logic               timer_clearn;
  logic               timer_en;
  logic               mag_on;
  logic               done;

  modport master (
    output key_valid, key_digit, start_btn, stop_btn, door_closed, timer_zero,
    input  timer_data, timer_loadn, timer_clearn, timer_en, mag_on, done
  );

  modport slave (
    input  key_valid, key_digit, start_btn, stop_btn, door_closed, timer_zero,
    output timer_data, timer_loadn, timer_clearn, timer_en, mag_on, done
  );

endinterface

// File: rtl/oven_ctrl_rise_det.sv
// rise_det: turns a synchronous button level into a one-cycle pulse on its
// 0->1 transition by comparing the current level with last cycle's level.
module rise_det (
  input  logic clock,
  input  logic clear,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Remember the previous level; cleared low so a button held through reset
  // is seen as a fresh press once reset releases.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/oven_ctrl.sv
// oven_ctrl: sequencing controller between the keypad encoder and the MM:SS
// countdown timer. Loads up to MAX_DIGITS keypad digits into the timer, runs
// the timer and magnetron while cooking, pauses on door open or stop, and
// flags completion when the timer reaches zero.
// Optional build macro DONE_BEEP_EN: done becomes a BEEP_CYCLES-long pulse on
// entry to DONE instead of a level held for the whole DONE state.
module oven_ctrl
  import oven_pkg::*;
#(
  parameter int MAX_DIGITS = 4
`ifdef DONE_BEEP_EN
  , parameter int BEEP_CYCLES = 3
`endif
) (
  input logic        clock,
  input logic        clear,
  oven_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DIGIT_W-1:0] data_q, data_d;
  logic               loadn_q, loadn_d;
  logic               clearn_q, clearn_d;
  logic               en_q, en_d;
  logic               mag_q, mag_d;
  logic               done_q, done_d;
  logic               start_edge, stop_edge;
  logic               key_ok, cook_ok, key_load, to_idle;

`ifdef DONE_BEEP_EN
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);
  logic [BEEP_W-1:0] beep_q, beep_d;
`endif

  rise_det u_start_det (
    .clock (clock),
    .clear (clear),
    .level (bus.start_btn),
    .rise  (start_edge)
  );

  rise_det u_stop_det (
    .clock (clock),
    .clear (clear),
    .level (bus.stop_btn),
    .rise  (stop_edge)
  );

  // Next state and next output values; door open outranks timer_zero, which
  // outranks stop, then start, then keys.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    data_d   = data_q;
    loadn_d  = 1'b1;
    clearn_d = 1'b1;
    key_load = 1'b0;
    key_ok   = bus.key_valid && is_bcd(bus.key_digit) &&
               (count_q < CNT_W'(MAX_DIGITS));
    cook_ok  = start_edge && bus.door_closed && !bus.timer_zero;

    case (state_q)
      ST_IDLE: begin
        if (key_ok) begin
          key_load = 1'b1;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (stop_edge)    state_d  = ST_IDLE;
        else if (cook_ok) state_d  = ST_COOKING;
        else if (key_ok)  key_load = 1'b1;
      end
      ST_COOKING: begin
        if (!bus.door_closed)    state_d = ST_PAUSED;
        else if (bus.timer_zero) state_d = ST_DONE;
        else if (stop_edge)      state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (!bus.door_closed) state_d = ST_PAUSED;
        else if (stop_edge)   state_d = ST_IDLE;
        else if (cook_ok)     state_d = ST_COOKING;
      end
      ST_DONE: begin
        if (bus.key_valid || stop_edge || !bus.door_closed) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (key_load) begin
      data_d  = bus.key_digit;
      loadn_d = 1'b0;
      count_d = count_q + CNT_W'(1);
    end

    to_idle = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    if (to_idle) begin
      clearn_d = 1'b0;
      count_d  = '0;
    end

    en_d  = (state_d == ST_COOKING);
    mag_d = (state_d == ST_COOKING);

`ifdef DONE_BEEP_EN
    beep_d = beep_q;
    if ((state_d == ST_DONE) && (state_q != ST_DONE))
      beep_d = BEEP_W'(BEEP_CYCLES - 1);
    else if ((state_q == ST_DONE) && (beep_q != '0))
      beep_d = beep_q - BEEP_W'(1);
    done_d = (state_d == ST_DONE) && ((state_q != ST_DONE) || (beep_q != '0));
`else
    done_d = (state_d == ST_DONE);
`endif
  end

  // State, digit count and every output are registered; reset holds the
  // timer in clear and everything else off.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      data_q   <= '0;
      loadn_q  <= 1'b1;
      clearn_q <= 1'b0;
      en_q     <= 1'b0;
      mag_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      data_q   <= data_d;
      loadn_q  <= loadn_d;
      clearn_q <= clearn_d;
      en_q     <= en_d;
      mag_q    <= mag_d;
      done_q   <= done_d;
    end
  end

`ifdef DONE_BEEP_EN
  // Cycles of beep remaining after the current one while in DONE.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) beep_q <= '0;
    else       beep_q <= beep_d;
  end
`endif

  assign bus.timer_data   = data_q;
  assign bus.timer_loadn  = loadn_q;
  assign bus.timer_clearn = clearn_q;
  assign bus.timer_en     = en_q;
  assign bus.mag_on       = mag_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_oven_ctrl.sv
// tb_oven_ctrl: directed scenarios followed by randomized stimulus. Each
// stimulus cycle steps a reference model and queues the expected outputs; a
// monitor pops and compares them one after every rising clock edge.
module tb_oven_ctrl;
  import oven_pkg::*;

  localparam int MAX_DIGITS = 4;
`ifdef DONE_BEEP_EN
  localparam int BEEP_CYCLES = 3;
  localparam int EXP_DONE    = 3;
`else
  localparam int EXP_DONE    = 10;
`endif

  typedef struct packed {
    logic [3:0] data;
    logic       loadn;
    logic       clearn;
    logic       en;
    logic       mag;
    logic       done;
  } out_t;

  typedef struct {
    bit clr;
    bit kv;
    int digit;
    bit start;
    bit stop;
    bit door;
    bit zero;
  } stim_t;

  logic clock = 1'b0;
  logic clear;

  oven_ctrl_if bus ();

  oven_ctrl dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  int   seen_loads, seen_done, seen_clears;
  int   load_log[$];

  // reference model: mode name, digits accepted so far, button history
  string m_mode;
  int    m_digits[$];
  bit    m_prev_start, m_prev_stop;
  int    m_done_age;
  logic [3:0] m_data;

  bit lv_start, lv_stop, lv_door, lv_zero;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_mode = "IDLE";
    m_digits.delete();
    m_prev_start = 1'b0;
    m_prev_stop  = 1'b0;
    m_done_age   = 0;
    m_data       = 4'd0;
  endtask

  task automatic modelStep(input stim_t s, output out_t o);
    string nxt;
    bit start_edge, stop_edge, key_ok, load;
    start_edge   = s.start && !m_prev_start;
    stop_edge    = s.stop && !m_prev_stop;
    m_prev_start = s.start;
    m_prev_stop  = s.stop;
    key_ok = s.kv && (s.digit <= 9) && (m_digits.size() < MAX_DIGITS);
    nxt  = m_mode;
    load = 1'b0;
    if (m_mode == "IDLE") begin
      load = key_ok;
    end else if (m_mode == "ENTRY") begin
      if (stop_edge) nxt = "IDLE";
      else if (start_edge && s.door && !s.zero) nxt = "COOKING";
      else load = key_ok;
    end else if (m_mode == "COOKING") begin
      if (!s.door) nxt = "PAUSED";
      else if (s.zero) nxt = "DONE";
      else if (stop_edge) nxt = "PAUSED";
    end else if (m_mode == "PAUSED") begin
      if (s.door) begin
        if (stop_edge) nxt = "IDLE";
        else if (start_edge && !s.zero) nxt = "COOKING";
      end
    end else begin
      if (s.kv || stop_edge || !s.door) nxt = "IDLE";
    end
    if (load) begin
      m_digits.push_back(s.digit);
      m_data = 4'(s.digit);
      if (m_mode == "IDLE") nxt = "ENTRY";
    end
    o.data   = m_data;
    o.loadn  = !load;
    o.clearn = !((m_mode != "IDLE") && (nxt == "IDLE"));
    if (!o.clearn) m_digits.delete();
    o.en  = (nxt == "COOKING");
    o.mag = (nxt == "COOKING");
    m_done_age = ((nxt == "DONE") && (m_mode == "DONE")) ? m_done_age + 1 : 0;
`ifdef DONE_BEEP_EN
    o.done = (nxt == "DONE") && (m_done_age < BEEP_CYCLES);
`else
    o.done = (nxt == "DONE");
`endif
    m_mode = nxt;
  endtask

  task automatic applyStimulus(input stim_t s);
    out_t e;
    @(negedge clock);
    clear           = s.clr;
    bus.key_valid   = s.kv;
    bus.key_digit   = 4'(s.digit);
    bus.start_btn   = s.start;
    bus.stop_btn    = s.stop;
    bus.door_closed = s.door;
    bus.timer_zero  = s.zero;
    if (s.clr) begin
      modelReset();
      e = '{data: 4'd0, loadn: 1'b1, clearn: 1'b0, en: 1'b0, mag: 1'b0, done: 1'b0};
    end else begin
      modelStep(s, e);
    end
    exp_q.push_back(e);
  endtask

  task automatic tick(input bit kv = 1'b0, input int digit = 0, input bit clr = 1'b0);
    stim_t s;
    s.clr   = clr;
    s.kv    = kv;
    s.digit = digit;
    s.start = lv_start;
    s.stop  = lv_stop;
    s.door  = lv_door;
    s.zero  = lv_zero;
    applyStimulus(s);
  endtask

  task automatic startCooking();
    lv_start = 1'b1; tick();
    lv_start = 1'b0; tick();
  endtask

  task automatic stopPress();
    lv_stop = 1'b1; tick();
    lv_stop = 1'b0; tick();
  endtask

  // monitor: compare the queued expectation after every rising edge
  initial begin
    out_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("timer_data",   int'(bus.timer_data),   int'(e.data));
        checkOutput("timer_loadn",  int'(bus.timer_loadn),  int'(e.loadn));
        checkOutput("timer_clearn", int'(bus.timer_clearn), int'(e.clearn));
        checkOutput("timer_en",     int'(bus.timer_en),     int'(e.en));
        checkOutput("mag_on",       int'(bus.mag_on),       int'(e.mag));
        checkOutput("done",         int'(bus.done),         int'(e.done));
        if (!bus.timer_loadn) begin
          seen_loads++;
          load_log.push_back(int'(bus.timer_data));
        end
        if (bus.done) seen_done++;
        if (!bus.timer_clearn) seen_clears++;
      end
    end
  end

  // watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] run did not complete");
  end

  // stimulus
  initial begin
    int exp_keys[4];
    exp_keys = '{0, 1, 3, 0};
    clear           = 1'b1;
    bus.key_valid   = 1'b0;
    bus.key_digit   = 4'd0;
    bus.start_btn   = 1'b0;
    bus.stop_btn    = 1'b0;
    bus.door_closed = 1'b1;
    bus.timer_zero  = 1'b0;
    lv_start = 1'b0; lv_stop = 1'b0; lv_door = 1'b1; lv_zero = 1'b0;
    modelReset();

    #1;
    checkOutput("reset_data",   int'(bus.timer_data),   0);
    checkOutput("reset_loadn",  int'(bus.timer_loadn),  1);
    checkOutput("reset_clearn", int'(bus.timer_clearn), 0);
    checkOutput("reset_en",     int'(bus.timer_en),     0);
    checkOutput("reset_mag",    int'(bus.mag_on),       0);
    checkOutput("reset_done",   int'(bus.done),         0);

    tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b1);
    tick();
    tick();

    // four digits load, the fifth is dropped
    seen_loads = 0;
    load_log.delete();
    tick(1'b1, 0); tick();
    tick(1'b1, 1); tick();
    tick(1'b1, 3);
    tick(1'b1, 0);
    tick(1'b1, 5);
    tick();
    tick();
    checkOutput("load_pulses", seen_loads, 4);
    for (int i = 0; i < 4; i++)
      checkOutput("load_digit", (load_log.size() > i) ? load_log[i] : -1, exp_keys[i]);

    // cook until the timer reaches zero, then dwell in DONE
    startCooking();
    repeat (3) tick();
    seen_done = 0;
    lv_zero = 1'b1;
    tick();
    repeat (9) tick();
    tick(1'b1, 2);
    tick();
    checkOutput("done_cycles", seen_done, EXP_DONE);
    lv_zero = 1'b0;
    tick();

    // door pause, resume, then stop twice back to IDLE
    tick(1'b1, 1); tick(1'b1, 2); tick();
    startCooking();
    lv_door = 1'b0; tick(); tick();
    lv_door = 1'b1; tick();
    startCooking();
    tick();
    seen_clears = 0;
    stopPress();
    stopPress();
    tick();
    checkOutput("stop_clear_pulses", seen_clears, 1);

    // timer_zero and stop edge in the same cycle while cooking
    tick(1'b1, 4); tick(1'b1, 2); tick();
    startCooking();
    lv_zero = 1'b1; lv_stop = 1'b1; tick();
    lv_stop = 1'b0; tick(); tick();
    lv_zero = 1'b0; tick(1'b1, 7); tick();

    // start edge with the door open while paused
    tick(1'b1, 9); tick();
    startCooking();
    stopPress();
    lv_door = 1'b0; lv_start = 1'b1; tick();
    lv_start = 1'b0; tick();
    lv_door = 1'b1; tick();
    stopPress();
    tick();

    // asynchronous reset while cooking
    tick(1'b1, 5); tick(1'b1, 0); tick();
    startCooking();
    tick();
    @(negedge clock);
    clear = 1'b1;
    #1;
    checkOutput("async_en",     int'(bus.timer_en),     0);
    checkOutput("async_mag",    int'(bus.mag_on),       0);
    checkOutput("async_clearn", int'(bus.timer_clearn), 0);
    tick(1'b0, 0, 1'b1);
    tick();
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rclr;
      bit rkv;
      if ($urandom_range(99) < 8) lv_start = !lv_start;
      if ($urandom_range(99) < 6) lv_stop  = !lv_stop;
      if (lv_door) lv_door = ($urandom_range(99) >= 3);
      else         lv_door = ($urandom_range(99) < 30);
      lv_zero = ($urandom_range(99) < 5);
      rkv  = ($urandom_range(99) < 30);
      rclr = ($urandom_range(999) < 3);
      tick(rkv, int'($urandom_range(15)), rclr);
    end
    tick();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    checkOutput("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
